ed25519_io_frame: RTL and testbench

Stream framing unit between the 64-bit valid/ready I/O ports of `ed25519` and the point-multiplication core. It deserialises `N_IN` operands of `PATN_W` bits arriving MSB-beat-first, hands them to the core with a start pulse, and captures the core result. It then serialises the `N_OUT` result words back out MSB-beat-first under full backpressure. It is parametrised in bus width, operand width and operand counts, supports back-to-back frames, and can optionally overlap reception of the next frame with computation of the current one.

---
 rtl/ed25519_io_frame.sv | 191 +++++++++++++++++++
 tb/tb_ed25519_io_frame.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ed25519_io_frame.sv
// Stream framing between the 64-bit valid/ready I/O ports and the ed25519 point-multiplication core.
// Optional IO_FRAME_OVERLAP_EN: receive the next frame while the current one computes/sends.

// state   | meaning
// S_IDLE  | one settling cycle after reset
// S_RECV  | collecting operand beats (or waiting for a full buffer when overlapping)
// S_START | one-cycle core start pulse
// S_CALC  | waiting for the core done pulse
// S_SEND  | streaming result beats out under backpressure
module ed25519_io_frame #(
  parameter int DATA_W = 64,
  parameter int PATN_W = 256,
  parameter int N_IN   = 3,
  parameter int N_OUT  = 2
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_in_valid,
  output logic                      o_in_ready,
  input  logic [DATA_W-1:0]         i_in_data,
  output logic                      o_out_valid,
  input  logic                      i_out_ready,
  output logic [DATA_W-1:0]         o_out_data,
  output logic                      o_core_start,
  output logic [N_IN*PATN_W-1:0]    o_core_operands,
  input  logic                      i_core_done,
  input  logic [N_OUT*PATN_W-1:0]   i_core_result
);

  localparam int BEATS     = PATN_W / DATA_W;
  localparam int IN_BEATS  = N_IN * BEATS;
  localparam int OUT_BEATS = N_OUT * BEATS;
  localparam int IN_W      = N_IN * PATN_W;
  localparam int OUT_W     = N_OUT * PATN_W;
  localparam int IC_W      = $clog2(IN_BEATS + 1);
  localparam int OC_W      = $clog2(OUT_BEATS + 1);

  localparam logic [IC_W-1:0] IN_LAST  = IC_W'(IN_BEATS - 1);
  localparam logic [OC_W-1:0] OUT_LAST = OC_W'(OUT_BEATS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RECV,
    S_START,
    S_CALC,
    S_SEND
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [IN_W-1:0]   in_reg;
  logic [IN_W-1:0]   ops_reg;
  logic [OUT_W-1:0]  out_reg;
  logic [IC_W-1:0]   in_cnt;
  logic [OC_W-1:0]   out_cnt;
  logic              in_fire;
  logic              in_last;
  logic              out_fire;
  logic              out_last;
  logic              core_load;
  logic              ops_copy;

`ifdef IO_FRAME_OVERLAP_EN
  logic              in_full;
`endif

  assign in_fire   = i_in_valid & o_in_ready;
  assign in_last   = in_fire && (in_cnt == IN_LAST);
  assign out_fire  = o_out_valid & i_out_ready;
  assign out_last  = out_fire && (out_cnt == OUT_LAST);
  assign core_load = (state == S_CALC) && i_core_done;

  assign o_core_operands = ops_reg;
  assign o_out_data      = o_out_valid ? out_reg[OUT_W-1 -: DATA_W] : '0;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    o_in_ready   = 1'b0;
    o_out_valid  = 1'b0;
    o_core_start = 1'b0;
    ops_copy     = 1'b0;
`ifdef IO_FRAME_OVERLAP_EN
    // capture side runs independently of the main FSM once out of idle
    o_in_ready = (state != S_IDLE) && !in_full;
`endif
    case (state)
      S_IDLE: begin
        state_nxt = S_RECV;
      end
      S_RECV: begin
`ifdef IO_FRAME_OVERLAP_EN
        if (in_full) begin
          ops_copy  = 1'b1;
          state_nxt = S_START;
        end
`else
        o_in_ready = 1'b1;
        if (in_last) begin
          ops_copy  = 1'b1;
          state_nxt = S_START;
        end
`endif
      end
      S_START: begin
        o_core_start = 1'b1;
        state_nxt    = S_CALC;
      end
      S_CALC: begin
        if (i_core_done) begin
          state_nxt = S_SEND;
        end
      end
      S_SEND: begin
        o_out_valid = 1'b1;
        if (out_last) begin
          state_nxt = S_RECV;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // input deserialiser: first beat ends up in the MSBs after IN_BEATS shifts
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      in_reg <= '0;
      in_cnt <= '0;
    end else if (in_fire) begin
      in_reg <= {in_reg[IN_W-DATA_W-1:0], i_in_data};
      if (in_last) begin
        in_cnt <= '0;
      end else begin
        in_cnt <= in_cnt + IC_W'(1);
      end
    end
  end

`ifdef IO_FRAME_OVERLAP_EN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      in_full <= 1'b0;
    end else if (in_last) begin
      in_full <= 1'b1;
    end else if (ops_copy) begin
      in_full <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ops_reg <= '0;
    end else if (ops_copy) begin
      ops_reg <= in_reg;
    end
  end
`else
  // the final beat is still on the bus when the copy happens
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ops_reg <= '0;
    end else if (ops_copy) begin
      ops_reg <= {in_reg[IN_W-DATA_W-1:0], i_in_data};
    end
  end
`endif

  // output serialiser: top beat is always the one on the bus
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      out_reg <= '0;
      out_cnt <= '0;
    end else if (core_load) begin
      out_reg <= i_core_result;
      out_cnt <= '0;
    end else if (out_fire) begin
      out_reg <= out_reg << DATA_W;
      out_cnt <= out_cnt + OC_W'(1);
    end
  end

endmodule

// File: tb/tb_ed25519_io_frame.sv
// Self-checking bench for ed25519_io_frame: scoreboard queues for operands and result beats.
// Exercises the overlap scenario when IO_FRAME_OVERLAP_EN is defined.
module tb_ed25519_io_frame;

  localparam int DATA_W    = 64;
  localparam int PATN_W    = 256;
  localparam int N_IN      = 3;
  localparam int N_OUT     = 2;
  localparam int IN_BEATS  = 12;
  localparam int OUT_BEATS = 8;
`ifdef IO_FRAME_OVERLAP_EN
  localparam bit OVL = 1'b1;
`else
  localparam bit OVL = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [63:0]  in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [63:0]  out_data;
  logic         core_start;
  logic [767:0] core_operands;
  logic         core_done = 1'b0;
  logic [511:0] core_result = '0;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int cyc      = 0;
  logic [63:0] in_q[$];
  logic [63:0] out_q[$];
  bit rand_in  = 1'b0;
  bit rand_out = 1'b0;
  int last_in_edge, done_edge, last_out_edge, start_edge;

  ed25519_io_frame #(
    .DATA_W(DATA_W), .PATN_W(PATN_W), .N_IN(N_IN), .N_OUT(N_OUT)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_in_valid     (in_valid),
    .o_in_ready     (in_ready),
    .i_in_data      (in_data),
    .o_out_valid    (out_valid),
    .i_out_ready    (out_ready),
    .o_out_data     (out_data),
    .o_core_start   (core_start),
    .o_core_operands(core_operands),
    .i_core_done    (core_done),
    .i_core_result  (core_result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got %0d checks, required completion", chk_cnt);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic send_frame(input logic [63:0] base);
    bit acc;
    int n;
    for (int i = 0; i < IN_BEATS; i++) begin
      acc = 1'b0;
      n   = 0;
      while (!acc && n < 500) begin
        @(negedge clk);
        in_valid = rand_in ? 1'($urandom_range(0, 1)) : 1'b1;
        in_data  = base + 64'(i);
        acc      = in_valid && in_ready;
        n++;
      end
      if (!acc) begin
        check("in_tmo", 64'(acc), 64'd1);
        in_valid = 1'b0;
        return;
      end
      in_q.push_back(in_data);
    end
    last_in_edge = cyc + 1;
    @(negedge clk);
    in_valid = 1'b0;
    check("rdy_fall", 64'(in_ready), 64'd0);
    check("start_lat", 64'(core_start), OVL ? 64'd0 : 64'd1);
  endtask

  task automatic core_task(input int fidx, input int lat);
    int n;
    logic [63:0] e;
    logic [511:0] res;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!core_start && n < 2000);
    if (!core_start) begin
      check("start_tmo", 64'(core_start), 64'd1);
      return;
    end
    start_edge = cyc;
    for (int i = 0; i < IN_BEATS; i++) begin
      e = (in_q.size() > 0) ? in_q.pop_front() : 64'hDEAD_DEAD_DEAD_DEAD;
      check("operand", core_operands[767-64*i -: 64], e);
    end
    @(negedge clk);
    check("start_1cyc", 64'(core_start), 64'd0);
    repeat (lat - 2) @(negedge clk);
    for (int k = 0; k < OUT_BEATS; k++) begin
      res[511-64*k -: 64] = 64'hA0 + 64'(8 * fidx + k);
      out_q.push_back(res[511-64*k -: 64]);
    end
    core_result = res;
    core_done   = 1'b1;
    done_edge   = cyc + 1;
    @(negedge clk);
    core_done   = 1'b0;
    core_result = '0;
    check("valid_lat", 64'(out_valid), 64'd1);
  endtask

  task automatic recv_beats(input int n_beats);
    int got;
    int n;
    bit stall;
    logic [63:0] held;
    logic [63:0] e;
    got   = 0;
    n     = 0;
    stall = 1'b0;
    held  = '0;
    while (got < n_beats && n < 3000) begin
      @(negedge clk);
      n++;
      out_ready = rand_out ? 1'($urandom_range(0, 1)) : 1'b1;
      if (stall) begin
        check("hold_valid", 64'(out_valid), 64'd1);
        check("hold_data", out_data, held);
      end
      if (!out_valid) check("idle_zero", out_data, 64'd0);
      stall = out_valid && !out_ready;
      held  = out_data;
      if (out_valid && out_ready) begin
        e = (out_q.size() > 0) ? out_q.pop_front() : 64'hBAD0_BAD0_BAD0_BAD0;
        check("out_beat", out_data, e);
        got++;
        last_out_edge = cyc + 1;
      end
    end
    if (got < n_beats) check("out_tmo", 64'(got), 64'(n_beats));
  endtask

  task automatic run_frame(input logic [63:0] base, input int fidx);
    fork
      send_frame(base);
      core_task(fidx, 10);
      recv_beats(OUT_BEATS);
    join
    @(negedge clk);
    out_ready = 1'b0;
    check("rdy_after_send", 64'(in_ready), 64'd1);
    check("valid_after_send", 64'(out_valid), 64'd0);
    check("q_empty", 64'(out_q.size() + in_q.size()), 64'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rdy"}, 64'(in_ready), 64'd0);
    check({tag, "_vld"}, 64'(out_valid), 64'd0);
    check({tag, "_dat"}, out_data, 64'd0);
    check({tag, "_start"}, 64'(core_start), 64'd0);
    check({tag, "_ops"}, 64'(|core_operands), 64'd0);
  endtask

  initial begin
    int a_done, a_last, b_in, b_start;

    // reset held for five cycles
    repeat (5) begin
      @(negedge clk);
      check_all_zero("rst");
    end
    rst = 1'b0;
    #1;
    check("idle_rdy", 64'(in_ready), 64'd0);
    @(negedge clk);
    check("startup_rdy", 64'(in_ready), 64'd1);
    check("startup_vld", 64'(out_valid), 64'd0);

    // a done pulse outside S_CALC must be ignored
    core_result = '1;
    core_done   = 1'b1;
    @(negedge clk);
    core_done   = 1'b0;
    core_result = '0;
    check("spurious_done_vld", 64'(out_valid), 64'd0);
    check("spurious_done_rdy", 64'(in_ready), 64'd1);

    // packing and serialisation, full throughput
    run_frame(64'h1, 0);

    // random handshake on both sides
    rand_in  = 1'b1;
    rand_out = 1'b1;
    run_frame(64'h1, 0);
    run_frame(64'h100, 1);
    rand_in  = 1'b0;
    rand_out = 1'b0;

    // reset after three output beats
    fork
      send_frame(64'h200);
      core_task(2, 10);
      recv_beats(3);
    join
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_all_zero("midrst");
    repeat (3) @(negedge clk);
    out_q.delete();
    in_q.delete();
    rst = 1'b0;
    run_frame(64'h300, 3);

`ifdef IO_FRAME_OVERLAP_EN
    // frame B arrives while frame A computes
    fork
      begin
        send_frame(64'h400);
        send_frame(64'h500);
        b_in = last_in_edge;
      end
      begin
        core_task(4, 30);
        a_done = done_edge;
        core_task(5, 10);
        b_start = start_edge;
      end
      begin
        recv_beats(OUT_BEATS);
        a_last = last_out_edge;
        recv_beats(OUT_BEATS);
      end
    join
    check("ovl_in_before_done", 64'(b_in < a_done), 64'd1);
    // start visible in the cycle after edge K+1, where K accepted A's last beat
    check("ovl_start_gap", 64'(b_start - a_last), 64'd1);
    @(negedge clk);
    out_ready = 1'b0;
    check("ovl_q_empty", 64'(out_q.size() + in_q.size()), 64'd0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
